// File: rtl/ahb_prot_filter.sv
// ahb_prot_filter: AHB-Lite region permission filter with two-cycle ERROR, sticky fault log and optional violation counter (AHB_PROT_FILTER_CNT_EN)
module ahb_prot_filter #(
  parameter int ADDR_W      = 32,
  parameter int PROT_W      = 4,
  parameter int NUM_REGIONS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hsel,
  input  logic [ADDR_W-1:0]             haddr,
  input  logic [1:0]                    htrans,
  input  logic                          hwrite,
  input  logic [PROT_W-1:0]             hprot,
  input  logic                          hready,
  output logic                          hreadyout,
  output logic                          hresp,
  output logic                          hsel_s,
  input  logic                          hreadyout_s,
  input  logic                          hresp_s,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
  input  logic [NUM_REGIONS*3-1:0]      region_perm,
  output logic                          fault_valid,
  output logic [ADDR_W-1:0]             fault_addr,
  output logic [PROT_W-1:0]             fault_prot,
  output logic                          fault_write,
  input  logic                          fault_clr,
  output logic [CNT_W-1:0]              viol_count,
  output logic                          dp_opcode,
  output logic                          dp_priv,
  output logic                          dp_buf,
  output logic                          dp_cache,
  output logic [2:0]                    dp_ext
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ERR1 = 2'd1;
  localparam logic [1:0] ERR2 = 2'd2;
  logic [1:0] state;
  logic       hit, deny, open, accept, viol, dp_fwd;
  logic [2:0] perm;
  logic [6:0] hp7;
  // hprot widened to 7 bits so the AHB5 extension bits read as zero on AHB-Lite
  assign hp7 = 7'(hprot);
  // region match; scanning downward leaves the lowest matching index in place
  always_comb begin
    hit  = 1'b0;
    perm = 3'b000;
    for (int i = NUM_REGIONS-1; i >= 0; i--)
      if ((haddr & region_mask[i*ADDR_W +: ADDR_W]) == (region_base[i*ADDR_W +: ADDR_W] & region_mask[i*ADDR_W +: ADDR_W])) begin
        hit  = 1'b1;
        perm = region_perm[i*3 +: 3];
      end
  end
  assign deny   = !hit | (!hp7[1] & !perm[0]) | (hwrite & !perm[1]) | (!hp7[0] & !perm[2]);
  assign open   = (state == IDLE) | (state == ERR2);
  assign accept = hsel & htrans[1] & hready & open;
  assign viol   = accept & deny;
  assign hsel_s = hsel & !deny & open;
  assign hreadyout = state == ERR1 ? 1'b0 : state == ERR2 ? 1'b1 : dp_fwd ? hreadyout_s : 1'b1;
  assign hresp     = open & (state != ERR2) ? (dp_fwd & hresp_s) : 1'b1;
  // error sequencer: ERR1 always advances, ERR2 can re-enter ERR1 on a fresh violation
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state == ERR1 ? ERR2 : viol ? ERR1 : IDLE;
  // data-phase forwarding flag and hprot decode for the current data phase
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dp_fwd    <= 1'b0;
      dp_opcode <= 1'b0;
      dp_priv   <= 1'b0;
      dp_buf    <= 1'b0;
      dp_cache  <= 1'b0;
      dp_ext    <= 3'b000;
    end else begin
      if (hready) dp_fwd <= accept & !deny;
      if (accept) begin
        dp_opcode <= ~hp7[0];
        dp_priv   <= hp7[1];
        dp_buf    <= hp7[2];
        dp_cache  <= hp7[3];
        dp_ext    <= hp7[6:4];
      end
    end
  // sticky fault log; a violation coinciding with a clear replaces the old record
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_prot  <= '0;
      fault_write <= 1'b0;
    end else if (viol) begin
      fault_valid <= 1'b1;
      if (!fault_valid | fault_clr) begin
        fault_addr  <= haddr;
        fault_prot  <= hprot;
        fault_write <= hwrite;
      end
    end else if (fault_clr) fault_valid <= 1'b0;
`ifdef AHB_PROT_FILTER_CNT_EN
  // saturating count of accepted denied transfers
  always_ff @(posedge clk or posedge rst)
    if (rst) viol_count <= '0;
    else if (viol && viol_count != {CNT_W{1'b1}}) viol_count <= viol_count + 1'b1;
`else
  assign viol_count = '0;
`endif
endmodule

// File: tb/tb_ahb_prot_filter.sv
// tb_ahb_prot_filter: directed checks of ahb_prot_filter on a 4-bit HPROT instance and a 7-bit, 2-bit-counter instance
module tb_ahb_prot_filter;
  logic        clk = 0, rst = 0, hsel = 0, hwrite = 0, hready = 1, hreadyout_s = 1, hresp_s = 0, fault_clr = 0;
  logic [31:0] haddr = 0;
  logic [1:0]  htrans = 0;
  logic [3:0]  hprot = 0;
  logic [6:0]  hprot7 = 0;
  logic [127:0] base0, mask0;
  logic [11:0]  perm0;
  logic [63:0]  base1, mask1;
  logic [5:0]   perm1;
  logic        hreadyout0, hresp0, hsel_s0, fault_valid0, fault_write0, dp_opcode0, dp_priv0, dp_buf0, dp_cache0;
  logic [31:0] fault_addr0;
  logic [3:0]  fault_prot0;
  logic [7:0]  viol_count0;
  logic [2:0]  dp_ext0;
  logic        hreadyout1, hresp1, hsel_s1, fault_valid1, fault_write1, dp_opcode1, dp_priv1, dp_buf1, dp_cache1;
  logic [31:0] fault_addr1;
  logic [6:0]  fault_prot1;
  logic [1:0]  viol_count1;
  logic [2:0]  dp_ext1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ahb_prot_filter u0 (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hprot(hprot),
    .hready(hready), .hreadyout(hreadyout0), .hresp(hresp0), .hsel_s(hsel_s0), .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s), .region_base(base0), .region_mask(mask0), .region_perm(perm0),
    .fault_valid(fault_valid0), .fault_addr(fault_addr0), .fault_prot(fault_prot0), .fault_write(fault_write0),
    .fault_clr(fault_clr), .viol_count(viol_count0), .dp_opcode(dp_opcode0), .dp_priv(dp_priv0),
    .dp_buf(dp_buf0), .dp_cache(dp_cache0), .dp_ext(dp_ext0));

  ahb_prot_filter #(.PROT_W(7), .NUM_REGIONS(2), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hprot(hprot7),
    .hready(hready), .hreadyout(hreadyout1), .hresp(hresp1), .hsel_s(hsel_s1), .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s), .region_base(base1), .region_mask(mask1), .region_perm(perm1),
    .fault_valid(fault_valid1), .fault_addr(fault_addr1), .fault_prot(fault_prot1), .fault_write(fault_write1),
    .fault_clr(fault_clr), .viol_count(viol_count1), .dp_opcode(dp_opcode1), .dp_priv(dp_priv1),
    .dp_buf(dp_buf1), .dp_cache(dp_cache1), .dp_ext(dp_ext1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ec(input int n);
`ifdef AHB_PROT_FILTER_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic w, input logic [3:0] p, input logic [6:0] p7);
    @(negedge clk);
    hsel = 1; htrans = 2'b10; haddr = a; hwrite = w; hprot = p; hprot7 = p7;
    #1;
  endtask

  task automatic idl();
    @(negedge clk);
    hsel = 0; htrans = 2'b00; hwrite = 0;
    #1;
  endtask

  initial begin
    base0 = {32'hDEAD0000, 32'hDEAD0000, 32'h00001000, 32'h00001000};
    mask0 = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFF000, 32'hFFFFF000};
    perm0 = {3'b111, 3'b111, 3'b000, 3'b111};
    base1 = {32'hFFFFFFFF, 32'h00001000};
    mask1 = {32'hFFFFFFFF, 32'hFFFFF000};
    perm1 = {3'b000, 3'b111};
    #2 rst = 1;
    #2;
    chk("rst_hreadyout", hreadyout0, 1);
    chk("rst_hresp", hresp0, 0);
    chk("rst_fault_valid", fault_valid0, 0);
    chk("rst_fault_addr", fault_addr0, 0);
    chk("rst_viol_count", viol_count0, 0);
    chk("rst_dp", {dp_opcode0, dp_priv0, dp_buf0, dp_cache0, dp_ext0}, 0);
    @(negedge clk) rst = 0;
    // permitted user write, slave response passed through
    drv(32'h1004, 1, 4'b0001, 7'h01);
    chk("t1_hsel_s", hsel_s0, 1);
    cyc();
    idl();
    hreadyout_s = 0;
    #1 chk("t1_pass_wait", hreadyout0, 0);
    hreadyout_s = 1;
    #1 chk("t1_pass_ready", hreadyout0, 1);
    chk("t1_viol_count", viol_count0, 0);
    chk("t1_dp_ext", dp_ext0, 0);
    cyc();
    // write denied by missing write_ok
    perm0[2:0] = 3'b101;
    drv(32'h1008, 1, 4'b0001, 7'h01);
    chk("t2_hsel_s", hsel_s0, 0);
    cyc();
    chk("t2_err1", {hreadyout0, hresp0}, 2'b01);
    chk("t2_fault_valid", fault_valid0, 1);
    chk("t2_fault_addr", fault_addr0, 32'h1008);
    chk("t2_fault_write", fault_write0, 1);
    chk("t2_fault_prot", fault_prot0, 4'b0001);
    chk("t2_viol_count", viol_count0, ec(1));
    idl();
    cyc();
    chk("t2_err2", {hreadyout0, hresp0}, 2'b11);
    cyc();
    chk("t2_idle", {hreadyout0, hresp0}, 2'b10);
    // no region hit while a fault is already logged
    drv(32'h9000, 0, 4'b0011, 7'h03);
    cyc();
    chk("t3_err1", {hreadyout0, hresp0}, 2'b01);
    chk("t3_fault_addr", fault_addr0, 32'h1008);
    chk("t3_viol_count", viol_count0, ec(2));
    idl();
    cyc();
    cyc();
    // back-to-back denials, the second accepted in ERR2 together with fault_clr
    drv(32'h9100, 0, 4'b0011, 7'h03);
    cyc();
    chk("t4_err1a", {hreadyout0, hresp0}, 2'b01);
    drv(32'h1000, 0, 4'b0001, 7'h01);
    chk("t4_err1_gate", hsel_s0, 0);
    cyc();
    chk("t4_err2a", {hreadyout0, hresp0}, 2'b11);
    drv(32'h9200, 0, 4'b0011, 7'h03);
    fault_clr = 1;
    cyc();
    chk("t4_err1b", {hreadyout0, hresp0}, 2'b01);
    chk("t4_fault_valid", fault_valid0, 1);
    chk("t4_fault_addr", fault_addr0, 32'h9200);
    chk("t4_viol_count", viol_count0, ec(4));
    drv(32'h1000, 0, 4'b0001, 7'h01);
    fault_clr = 0;
    cyc();
    chk("t4_err2b", {hreadyout0, hresp0}, 2'b11);
    drv(32'h1000, 0, 4'b0001, 7'h01);
    chk("t4_err2_fwd", hsel_s0, 1);
    cyc();
    idl();
    hresp_s = 1;
    #1 chk("t4_slave_resp", {hreadyout0, hresp0}, 2'b11);
    cyc();
    chk("t4_no_fwd", hresp0, 0);
    hresp_s = 0;
    @(negedge clk) fault_clr = 1;
    cyc();
    chk("t4_fault_clr", fault_valid0, 0);
    @(negedge clk) fault_clr = 0;
    // 7-bit HPROT instance with a 2-bit counter
    rst = 1;
    #1 chk("u1_rst", {hreadyout1, hresp1, viol_count1}, 4'b1000);
    @(negedge clk) rst = 0;
    drv(32'h1010, 0, 4'h0, 7'b1010110);
    chk("u1_hsel_s", hsel_s1, 1);
    cyc();
    chk("u1_dp", {dp_opcode1, dp_priv1, dp_buf1, dp_cache1, dp_ext1}, 7'b1110101);
    idl();
    for (int i = 0; i < 5; i++) begin
      drv(32'h9000, 0, 4'h3, 7'h03);
      cyc();
      idl();
      cyc();
      cyc();
    end
    chk("u1_sat", viol_count1, ec(3));
    chk("u1_fault_prot", fault_prot1, 7'h03);
    drv(32'h9000, 0, 4'h3, 7'h03);
    cyc();
    chk("u1_err1", {hreadyout1, hresp1}, 2'b01);
    #2 rst = 1;
    #1 chk("u1_rst_err", {hreadyout1, hresp1, viol_count1}, 4'b1000);
    chk("u1_rst_fault", fault_valid1, 0);
    idl();
    rst = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_prot_filter.md
# ahb_prot_filter

AHB-Lite protection filter placed between the interconnect slave port and one downstream slave. It decodes HPROT, which is 4-bit on AHB-Lite or 7-bit on AHB5, on every accepted address phase and checks the transfer against up to NUM_REGIONS address-region permission rules. Permitted transfers pass through to the slave. Denied transfers are blocked, answered with a two-cycle ERROR response, and logged in sticky fault registers and a violation counter.

## Interface
- ADDR_W, 32, address width
- PROT_W, 4, HPROT width; legal values 4 or 7
- NUM_REGIONS, 4, number of region rules, 1..16
- CNT_W, 8, violation counter width
- clk  in  1  bus clock
- rst  in  1  asynchronous, active-high reset
- hsel  in  1  slave select from interconnect
- haddr  in  ADDR_W  address
- htrans  in  2  transfer type
- hwrite  in  1  write strobe
- hprot  in  PROT_W  protection attributes
- hready  in  1  bus HREADY (muxed)
- hreadyout  out  1  ready returned to interconnect
- hresp  out  1  response returned to interconnect
- hsel_s  out  1  select forwarded to slave
- hreadyout_s  in  1  slave ready
- hresp_s  in  1  slave response
- region_base  in  NUM_REGIONS*ADDR_W  region i base, slice i
- region_mask  in  NUM_REGIONS*ADDR_W  region i compare mask
- region_perm  in  NUM_REGIONS*3  per region: bit0 user_ok, bit1 write_ok, bit2 exec_ok
- fault_valid  out  1  sticky fault flag
- fault_addr  out  ADDR_W  address of first uncleared violation
- fault_prot  out  PROT_W  hprot of that violation
- fault_write  out  1  hwrite of that violation
- fault_clr  in  1  clears fault_valid
- viol_count  out  CNT_W  saturating violation count
- dp_opcode, dp_priv, dp_buf, dp_cache  out  1 each  registered decode of the current data-phase hprot bits 0..3 (dp_opcode = ~hprot[0])
- dp_ext  out  3  registered hprot[6:4]; zero when PROT_W=4

## Operation
- Accepted address phase: hsel & htrans[1] & hready, in state IDLE or ERR2.
- Region hit: (haddr & mask_i) == (base_i & mask_i). The lowest index wins.
- Deny conditions:
  - no region hit (default deny);
  - user access (hprot[1]=0) and !user_ok;
  - hwrite and !write_ok;
  - opcode fetch (hprot[0]=0) and !exec_ok.
- hsel_s = hsel & !deny, combinational, gated off outside IDLE/ERR2.
- Data-phase register dp_fwd is set on an accepted permitted transfer.
- Response mux:
  - ERR1 drives hreadyout=0, hresp=1;
  - ERR2 drives hreadyout=1, hresp=1;
  - otherwise dp_fwd ? {hreadyout_s, hresp_s} : {1, 0}.
- FSM states:
  - IDLE: an accepted denied transfer moves to ERR1.
  - ERR1: unconditionally moves to ERR2; address phases are ignored.
  - ERR2: a new accepted denied transfer moves to ERR1; otherwise IDLE. A permitted transfer accepted here is forwarded normally.
- Fault capture on an accepted denied transfer, only when fault_valid=0: latch haddr, hprot, hwrite and set fault_valid. Later violations do not overwrite.
- fault_clr clears fault_valid next edge. Simultaneous violation and fault_clr: violation wins, the new fault is captured and fault_valid stays 1.
- dp_* register on every accepted address phase; they hold otherwise.

## Timing
- Reset values:
  - state IDLE;
  - hreadyout=1, hresp=0;
  - dp_fwd=0, fault_valid=0, fault_addr=0, fault_prot=0, fault_write=0;
  - viol_count=0, all dp_* = 0;
  - hsel_s follows its combinational equation.
- hsel_s has zero latency.
- Error response starts the cycle after the denied address phase and lasts exactly 2 cycles.
- Fault registers and counter update on the edge that accepts the denied address phase.
- viol_count saturates at 2^CNT_W-1 with no wrap.
- Reset asserted mid-error returns to IDLE immediately. Any partial ERROR response is abandoned.

## Configuration
- AHB_PROT_FILTER_CNT_EN
  - Defined: viol_count implemented as above.
  - Undefined: counter logic is removed and viol_count ties to 0. Fault registers are unaffected.

## Test plan
- Reset, then region0 base 0x1000 mask 0xFFFFF000 perm 3'b111; user write to 0x1004 -> hsel_s=1, slave response passed, viol_count=0.
- Same region with perm 3'b101; write to 0x1008 -> hsel_s=0, hreadyout 0 then 1, hresp 1 for 2 cycles, fault_addr=0x1008, fault_write=1, viol_count=1.
- Read 0x9000 (no region hit) while fault_valid=1 -> ERROR response, fault_addr stays 0x1008, viol_count=2.
- Back-to-back denied transfers, the second accepted in ERR2 -> states ERR1, ERR2, ERR1, ERR2; fault_clr asserted on that edge leaves fault_valid=1 with the new address.
- PROT_W=7, permitted fetch with hprot=7'b1010110 -> next cycle dp_opcode=1, dp_priv=1, dp_buf=1, dp_cache=0, dp_ext=3'b101.
- CNT_W=2 with 5 violations -> viol_count=3. Assert rst during ERR1 -> hreadyout=1, hresp=0, count=0.
